// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FP ALU widths, flag bit positions and the response entry layout.
package fpu_pkg;
   localparam int FP_W     = 32;
   localparam int FLAG_W   = 3;
   localparam int ID_MAX_W = 3;
   localparam int FLAG_EXC = 0;
   localparam int FLAG_UNF = 1;
   localparam int FLAG_OVF = 2;

   typedef struct packed {
      logic [ID_MAX_W-1:0] id;
      logic [FP_W-1:0]     result;
      logic [FLAG_W-1:0]   flags;
   } resp_t;
endpackage

// File: rtl/fpu_sync_fifo.sv
// fpu_sync_fifo: synchronous-reset FIFO with occupancy count; pop on empty is ignored.
module fpu_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic [WIDTH-1:0]             din,
   input  logic                         pop,
   output logic [WIDTH-1:0]             dout,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr, rd;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty  = (count == '0);
   assign do_pop = pop & ~empty;
   assign dout   = mem[rd];

   always_ff @(posedge clk) begin
      if (push) mem[wr] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr    <= '0;
         rd    <= '0;
         count <= '0;
      end else begin
         if (push) wr <= inc(wr);
         if (do_pop) rd <= inc(rd);
         count <= count + CNT_W'(push) - CNT_W'(do_pop);
      end
   end

   // Upstream credit accounting guarantees a free slot for every push.
   assert property (@(posedge clk) disable iff (rst) !(push && count == CNT_W'(DEPTH)));
endmodule

// File: rtl/fpu_mul_scheduler.sv
// fpu_mul_scheduler: round-robin sharing of one fixed-latency FP32 multiplier, tagged and credit-limited.
// Define FPMUL_SCHED_PRIO0_EN to give requester 0 strict priority over a round-robin among the rest.
module fpu_mul_scheduler
   import fpu_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int MUL_LAT    = 3,
   parameter int RESP_DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [FP_W*NUM_REQ-1:0]    req_a,
   input  logic [FP_W*NUM_REQ-1:0]    req_b,
   output logic                       mul_valid,
   output logic [FP_W-1:0]            mul_a,
   output logic [FP_W-1:0]            mul_b,
   input  logic [FP_W-1:0]            mul_result,
   input  logic [FLAG_W-1:0]          mul_flags,
   output logic                       resp_valid,
   input  logic                       resp_ready,
   output logic [$clog2(NUM_REQ)-1:0] resp_id,
   output logic [FP_W-1:0]            resp_result,
   output logic [FLAG_W-1:0]          resp_flags
);
   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int FC_W  = $clog2(RESP_DEPTH + 1);
   localparam int CNT_W = $clog2(RESP_DEPTH + MUL_LAT + 2) + 1;
`ifdef FPMUL_SCHED_PRIO0_EN
   localparam logic [ID_W-1:0] PTR_RST = ID_W'(1);
`else
   localparam logic [ID_W-1:0] PTR_RST = '0;
`endif

   logic [ID_W-1:0]  ptr, ptr_nxt, win, idx, issue_id;
   logic             found, grant;
   logic [CNT_W-1:0] cnt;
   logic [MUL_LAT-1:0] tag_v;
   logic [ID_W-1:0]  tag_id [MUL_LAT];
   logic [FC_W-1:0]  fifo_count;
   logic             fifo_empty;
   resp_t            push_entry, head;

   // Every accepted request owns a FIFO slot until it is popped.
   always_comb begin
      cnt = CNT_W'(mul_valid) + CNT_W'(fifo_count);
      for (int i = 0; i < MUL_LAT; i++) cnt = cnt + CNT_W'(tag_v[i]);
   end

   always_comb begin
      win   = '0;
      idx   = '0;
      found = 1'b0;
`ifdef FPMUL_SCHED_PRIO0_EN
      if (req_valid[0]) found = 1'b1;
      for (int k = 0; k < NUM_REQ - 1; k++) begin
         idx = ID_W'(1 + (int'(ptr) - 1 + k) % (NUM_REQ - 1));
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
      ptr_nxt = (win == '0) ? ptr : (win == ID_W'(NUM_REQ - 1)) ? ID_W'(1) : win + 1'b1;
`else
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = ID_W'((int'(ptr) + k) % NUM_REQ);
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
      ptr_nxt = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
`endif
      grant     = found && !rst && (cnt < CNT_W'(RESP_DEPTH));
      req_ready = grant ? (NUM_REQ'(1) << win) : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr       <= PTR_RST;
         mul_valid <= 1'b0;
         mul_a     <= '0;
         mul_b     <= '0;
         issue_id  <= '0;
         tag_v     <= '0;
         for (int i = 0; i < MUL_LAT; i++) tag_id[i] <= '0;
      end else begin
         mul_valid <= grant;
         tag_v[0]  <= mul_valid;
         tag_id[0] <= issue_id;
         for (int i = 1; i < MUL_LAT; i++) begin
            tag_v[i]  <= tag_v[i-1];
            tag_id[i] <= tag_id[i-1];
         end
         if (grant) begin
            mul_a    <= req_a[int'(win)*FP_W +: FP_W];
            mul_b    <= req_b[int'(win)*FP_W +: FP_W];
            issue_id <= win;
            ptr      <= ptr_nxt;
         end
      end
   end

   assign push_entry = '{id: ID_MAX_W'(tag_id[MUL_LAT-1]), result: mul_result, flags: mul_flags};

   fpu_sync_fifo #(
      .WIDTH($bits(resp_t)),
      .DEPTH(RESP_DEPTH)
   ) u_resp_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (tag_v[MUL_LAT-1]),
      .din   (push_entry),
      .pop   (resp_ready),
      .dout  (head),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Storage is not reset, so the outputs are forced to zero while empty.
   assign resp_valid  = ~fifo_empty;
   assign resp_id     = resp_valid ? ID_W'(head.id) : '0;
   assign resp_result = resp_valid ? head.result : '0;
   assign resp_flags  = resp_valid ? head.flags : '0;
endmodule

// File: tb/tb_fpu_mul_scheduler.sv
// tb_fpu_mul_scheduler: vector table, hand sequences and random traffic against a transaction-level model.
module tb_fpu_mul_scheduler;
   localparam int N = 4, LAT = 3, DEPTH = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   req_valid, req_ready;
   logic [127:0] req_a, req_b;
   logic         mul_valid;
   logic [31:0]  mul_a, mul_b, mul_result;
   logic [2:0]   mul_flags;
   logic         resp_valid, resp_ready;
   logic [1:0]   resp_id;
   logic [31:0]  resp_result;
   logic [2:0]   resp_flags;

   always #5 clk = ~clk;

   fpu_mul_scheduler #(.NUM_REQ(N), .MUL_LAT(LAT), .RESP_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b),
      .mul_result(mul_result), .mul_flags(mul_flags), .resp_valid(resp_valid),
      .resp_ready(resp_ready), .resp_id(resp_id), .resp_result(resp_result), .resp_flags(resp_flags)
   );

   // Truncating FP32 multiply returning {overflow, underflow, exception, product}.
   function automatic logic [34:0] fmul(input logic [31:0] a, input logic [31:0] b);
      logic s;
      int e;
      logic [47:0] m;
      logic [22:0] f;
      s = a[31] ^ b[31];
      if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {3'b001, s, 8'hFF, 23'h0};
      if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {3'b000, s, 31'h0};
      e = int'(a[30:23]) + int'(b[30:23]) - 127;
      m = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
      if (m[47]) begin
         f = m[46:24];
         e++;
      end else f = m[45:23];
      if (e >= 255) return {3'b100, s, 8'hFF, 23'h0};
      if (e <= 0) return {3'b010, s, 31'h0};
      return {3'b000, s, 8'(e), f};
   endfunction

   logic [34:0] mp [LAT];
   always @(posedge clk) begin
      mp[0] <= fmul(mul_a, mul_b);
      for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
   end
   assign mul_result = mp[LAT-1][31:0];
   assign mul_flags  = mp[LAT-1][34:32];

   typedef struct { int id; logic [31:0] res; logic [2:0] fl; } exp_t;
   typedef struct { int id; logic [31:0] a; logic [31:0] b; logic [31:0] res; logic [2:0] fl; } vec_t;

   exp_t  exp_q[$];
   int    gnt_q[$];
   int    n_chk = 0, n_fail = 0;
   int    mptr, outst;
   logic  prev_acc, hold_v;
   logic [31:0] prev_a, prev_b, hold_res;
   logic [1:0]  hold_id;
   logic [2:0]  hold_fl;
`ifdef FPMUL_SCHED_PRIO0_EN
   localparam int PRST = 1;
`else
   localparam int PRST = 0;
`endif

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference arbiter: who should win given the valid vector and the rotation point.
   function automatic int m_win(input logic [3:0] v, input int p);
`ifdef FPMUL_SCHED_PRIO0_EN
      if (v[0]) return 0;
      for (int k = 0; k < N - 1; k++) if (v[1 + (p - 1 + k) % (N - 1)]) return 1 + (p - 1 + k) % (N - 1);
`else
      for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
`endif
      return -1;
   endfunction

   task automatic model_reset();
      mptr = PRST;
      outst = 0;
      exp_q.delete();
      prev_acc = 1'b0;
      hold_v = 1'b0;
   endtask

   // One clock: check settled outputs, record handshakes, advance the model past the edge.
   task automatic step();
      int w;
      logic [3:0] er;
      logic acc, pop;
      #1;
      w  = m_win(req_valid, mptr);
      er = (rst || w < 0 || outst >= DEPTH) ? 4'b0 : 4'(1 << w);
      chk("req_ready", 64'(req_ready), 64'(er));
      chk("mul_valid", 64'(mul_valid), 64'(prev_acc));
      if (prev_acc) begin
         chk("mul_a", 64'(mul_a), 64'(prev_a));
         chk("mul_b", 64'(mul_b), 64'(prev_b));
      end
      if (hold_v) begin
         chk("hold_valid", 64'(resp_valid), 64'(1));
         chk("hold_id", 64'(resp_id), 64'(hold_id));
         chk("hold_result", 64'(resp_result), 64'(hold_res));
      end
      chk("stale_resp", 64'(resp_valid && exp_q.size() == 0), 64'(0));
      pop = resp_valid & resp_ready & ~rst;
      if (pop && exp_q.size() != 0) begin
         chk("resp_id", 64'(resp_id), 64'(exp_q[0].id));
         chk("resp_result", 64'(resp_result), 64'(exp_q[0].res));
         chk("resp_flags", 64'(resp_flags), 64'(exp_q[0].fl));
         void'(exp_q.pop_front());
      end
      acc = (er != 4'b0);
      hold_v = resp_valid & ~resp_ready & ~rst;
      hold_id = resp_id;
      hold_res = resp_result;
      hold_fl = resp_flags;
      prev_acc = acc;
      if (acc) begin
         prev_a = req_a[w*32 +: 32];
         prev_b = req_b[w*32 +: 32];
      end
      @(posedge clk);
      #1;
      if (rst) model_reset();
      else begin
         outst = outst + int'(acc) - int'(pop);
         if (acc) begin
            logic [34:0] p;
            p = fmul(prev_a, prev_b);
            exp_q.push_back('{w, p[31:0], p[34:32]});
            gnt_q.push_back(w);
`ifdef FPMUL_SCHED_PRIO0_EN
            if (w != 0) mptr = (w == N - 1) ? 1 : w + 1;
`else
            mptr = (w + 1) % N;
`endif
         end
      end
   endtask

   task automatic drain(input string name);
      req_valid = '0;
      resp_ready = 1'b1;
      for (int i = 0; i < 60 && (exp_q.size() != 0 || outst != 0); i++) step();
      chk(name, 64'(exp_q.size()), 64'(0));
   endtask

   vec_t tbl[5];

   initial begin
      tbl[0] = '{2, 32'h40000000, 32'h40400000, 32'h40C00000, 3'b000};
      tbl[1] = '{1, 32'h7F800000, 32'h40000000, 32'h7F800000, 3'b001};
      tbl[2] = '{3, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000};
      tbl[3] = '{0, 32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b100};
      tbl[4] = '{1, 32'h00800000, 32'h00800000, 32'h00000000, 3'b010};
      rst = 1'b1;
      req_valid = '0;
      req_a = '0;
      req_b = '0;
      resp_ready = 1'b1;
      model_reset();
      step();
      step();
      rst = 1'b0;
      chk("rst_mul_valid", 64'(mul_valid), 64'(0));
      chk("rst_mul_a", 64'(mul_a), 64'(0));
      chk("rst_mul_b", 64'(mul_b), 64'(0));
      chk("rst_resp_valid", 64'(resp_valid), 64'(0));
      chk("rst_resp_fields", 64'({resp_id, resp_result, resp_flags}), 64'(0));

      // Single requests: exact latency and result/flag pass-through.
      foreach (tbl[v]) begin
         req_valid = 4'(1 << tbl[v].id);
         req_a = {4{$urandom()}};
         req_b = {4{$urandom()}};
         req_a[tbl[v].id*32 +: 32] = tbl[v].a;
         req_b[tbl[v].id*32 +: 32] = tbl[v].b;
         step();
         req_valid = '0;
         for (int k = 1; k <= LAT + 1; k++) begin
            chk("lat_early", 64'(resp_valid), 64'(0));
            step();
         end
         chk("lat_valid", 64'(resp_valid), 64'(1));
         chk("vec_id", 64'(resp_id), 64'(tbl[v].id));
         chk("vec_result", 64'(resp_result), 64'(tbl[v].res));
         chk("vec_flags", 64'(resp_flags), 64'(tbl[v].fl));
         drain("vec_drain");
      end

      // All requesters streaming: one grant every cycle, rotating.
      gnt_q.delete();
      req_valid = 4'hF;
      for (int i = 0; i < 12; i++) begin
         req_a = {$urandom(), $urandom(), $urandom(), $urandom()};
         req_b = {$urandom(), $urandom(), $urandom(), $urandom()};
         step();
      end
      chk("stream_grants", 64'(gnt_q.size()), 64'(12));
      for (int i = 1; i < gnt_q.size(); i++)
`ifdef FPMUL_SCHED_PRIO0_EN
         chk("stream_order", 64'(gnt_q[i]), 64'(0));
`else
         chk("stream_order", 64'(gnt_q[i]), 64'((gnt_q[i-1] + 1) % N));
`endif
      drain("stream_drain");

      // Back-pressure: exactly DEPTH accepts, then the grant stops.
      gnt_q.delete();
      req_valid = 4'hF;
      resp_ready = 1'b0;
      for (int i = 0; i < 20; i++) step();
      chk("bp_accepts", 64'(gnt_q.size()), 64'(DEPTH));
      #1;
      chk("bp_blocked", 64'(req_ready), 64'(0));
      drain("bp_drain");

      // Reset with three requests in flight.
      req_valid = 4'hF;
      for (int i = 0; i < 3; i++) step();
      req_valid = '0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_resp_valid", 64'(resp_valid), 64'(0));
      chk("midrst_mul_valid", 64'(mul_valid), 64'(0));
      for (int i = 0; i < 10; i++) step();
      req_valid = 4'hF;
      #1;
      chk("midrst_first_grant", 64'(req_ready), 64'(1));
      step();
      drain("midrst_drain");

`ifdef FPMUL_SCHED_PRIO0_EN
      req_valid = 4'b0011;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("prio_req0", 64'(req_ready), 64'(1));
         step();
      end
      req_valid = 4'b0010;
      #1;
      chk("prio_req1", 64'(req_ready), 64'(2));
      step();
      drain("prio_drain");
`endif

      // Random traffic with random back-pressure.
      for (int i = 0; i < 400; i++) begin
         req_valid = 4'($urandom());
         req_a = {$urandom(), $urandom(), $urandom(), $urandom()};
         req_b = {$urandom(), $urandom(), $urandom(), $urandom()};
         resp_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      drain("rand_drain");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
